mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Single-clock arbiter and run controller for the unified word memory shared by the pipelined MIPS32 core.
- Multiplexes three requesters onto one single-port synchronous memory: instruction fetch (IF), data access (DM, MEM stage) and debug/loader (DBG).
- Sequences the core through boot load, run, drain and halted phases. The core advances only while core_run=1.

Parameters:
AW, 10, word-address width
DW, 32, data width
IF_MAX_WAIT, 4, consecutive IF denials before IF is forced ahead of DM for one grant

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; BOOT->RUN or HALTED->RUN
core_halted  in  1  HLT retired by core
core_run  out  1  pipeline enable
if_req  in  1  fetch request
if_addr  in  AW  fetch word address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid
if_rdata  out  DW  fetch data
dm_req  in  1  data request
dm_we  in  1  1=store
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_gnt  out  1  data accepted
dm_rvalid  out  1  load data valid
dm_rdata  out  DW  load data
dbg_req  in  1  debug request
dbg_we  in  1  1=write
dbg_addr  in  AW  debug address
dbg_wdata  in  DW  debug write data
dbg_gnt  out  1  debug accepted
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DW  debug read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid one cycle after mem_en&!mem_we
if_stall_cnt  out  16  saturating count of IF-denied cycles

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset state is BOOT. Reset values: core_run=0, all *_rvalid=0, all *_rdata=0, if_stall_cnt=0, IF wait counter=0, owner register=NONE.
- Grants and mem_* are combinational from the current state and requests. At most one gnt is high per cycle. mem_en equals the OR of the grants. mem_* mirror the granted requester. When nothing is granted, mem_we=0 and mem_addr/mem_wdata are held at 0.
- A read grant registers an owner ID. Next cycle the owner's rvalid=1 and its rdata=mem_rdata. Non-owners get rvalid=0 and rdata unchanged. Writes produce no rvalid.
- FSM:
  - BOOT: core_run=0; only DBG may be granted. On start -> RUN.
  - RUN: core_run=1; DBG never granted. DM beats IF unless the wait counter has reached IF_MAX_WAIT, in which case IF is granted and the counter clears. Counter increments on each cycle with if_req=1 and no if_gnt, saturates at IF_MAX_WAIT, and clears on if_gnt. On core_halted -> DRAIN.
  - DRAIN: core_run=0; no grants; the in-flight rvalid completes. -> HALTED next cycle.
  - HALTED: core_run=0; only DBG granted. On start -> RUN.
- start and core_halted in the same RUN cycle: core_halted wins.
- start in RUN or DRAIN: ignored.
- core_halted outside RUN: ignored.
- if_stall_cnt increments when if_req=1 and if_gnt=0 in RUN. It saturates at 0xFFFF and clears only on reset.
- Reset mid-operation discards any in-flight read: rvalid=0 and the owner register clears.
- No reordering: one request per cycle, one response per cycle, in grant order.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding BOOT=2'd0, RUN=2'd1, DRAIN=2'd2, HALTED=2'd3;
  - owner encoding NONE=2'd0, IF=2'd1, DM=2'd2, DBG=2'd3.
- AW/DW defaults are shared with the core.
- One natural sub-module, mips_arb_prio: a combinational DM/IF priority select plus the registered IF wait counter. The FSM and response routing stay at the top level.

Test Plan:
1. Reset, then DBG writes addr 0..8 with 0x2801000a..0xfc000000 in BOOT, then DBG reads addr 5 -> dbg_rvalid one cycle later with 0x00222000; if_gnt=0 and core_run=0 throughout.
2. start pulse, then if_req continuous at addr 0,1,2 -> core_run=1 next cycle; if_rvalid returns 0x2801000a, 0x28020014, 0x28030019 on consecutive cycles.
3. RUN with dm_req and if_req both held high for 10 cycles and IF_MAX_WAIT=4 -> grant pattern DM,DM,DM,DM,IF repeating; if_stall_cnt=8 afterwards.
4. core_halted and start asserted together in RUN with a DM read in flight -> dm_rvalid still fires; state goes DRAIN then HALTED; core_run=0; a dbg_req in HALTED is granted.
5. rst_n low for 1 cycle while an IF read is in flight -> no if_rvalid, state BOOT, if_stall_cnt=0, core_run=0.
6. dbg_req in RUN held for 20 cycles -> dbg_gnt never asserted. start pulse from HALTED -> RUN resumes with if_gnt on the next if_req.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings and default widths for the MIPS32 core and its memory arbiter.
package mips_pkg;
  localparam int MIPS_AW = 10;
  localparam int MIPS_DW = 32;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_DBG  = 2'd3
  } owner_t;
endpackage

// File: rtl/mips_arb_prio.sv
// DM-over-IF priority select with an anti-starvation wait counter for fetch.
module mips_arb_prio #(
  parameter int IF_MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic if_req,
  input  logic dm_req,
  output logic if_gnt,
  output logic dm_gnt
);
  localparam int CW = $clog2(IF_MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          if_due;

  assign if_due = (wait_cnt == CW'(IF_MAX_WAIT));

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (en) begin
      if (if_req && (!dm_req || if_due)) if_gnt = 1'b1;
      else if (dm_req)                   dm_gnt = 1'b1;
    end
  end

  // Counts denied fetch cycles; saturates so the forced grant stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         wait_cnt <= '0;
    else if (if_gnt)                    wait_cnt <= '0;
    else if (en && if_req && !if_due)   wait_cnt <= wait_cnt + 1'b1;
  end
endmodule

// File: rtl/mips_mem_arbiter.sv
// Run controller and single-port memory arbiter for IF, DM and debug requesters.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int AW          = MIPS_AW,
  parameter int DW          = MIPS_DW,
  parameter int IF_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          core_halted,
  output logic          core_run,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   if_stall_cnt
);
  state_t  state, state_d;
  owner_t  owner_q, owner_d;
  logic [DW-1:0] if_hold, dm_hold, dbg_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_BOOT:   if (start) state_d = ST_RUN;
      ST_RUN:    if (core_halted) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_HALTED;
      ST_HALTED: if (start) state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  assign core_run = (state == ST_RUN);
  assign dbg_gnt  = dbg_req && (state == ST_BOOT || state == ST_HALTED);

  mips_arb_prio #(.IF_MAX_WAIT(IF_MAX_WAIT)) u_prio (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (core_run),
    .if_req (if_req),
    .dm_req (dm_req),
    .if_gnt (if_gnt),
    .dm_gnt (dm_gnt)
  );

  assign mem_en = if_gnt | dm_gnt | dbg_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      owner_d   = dbg_we ? OWN_NONE : OWN_DBG;
    end else if (dm_gnt) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      owner_d   = dm_we ? OWN_NONE : OWN_DM;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
      owner_d   = OWN_IF;
    end
  end

  // Owner of the read whose data arrives on mem_rdata this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  assign if_rvalid  = (owner_q == OWN_IF);
  assign dm_rvalid  = (owner_q == OWN_DM);
  assign dbg_rvalid = (owner_q == OWN_DBG);

  // rdata passes memory data through on the valid cycle and holds it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_hold  <= '0;
      dm_hold  <= '0;
      dbg_hold <= '0;
    end else begin
      if (if_rvalid)  if_hold  <= mem_rdata;
      if (dm_rvalid)  dm_hold  <= mem_rdata;
      if (dbg_rvalid) dbg_hold <= mem_rdata;
    end
  end

  assign if_rdata  = if_rvalid  ? mem_rdata : if_hold;
  assign dm_rdata  = dm_rvalid  ? mem_rdata : dm_hold;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      if_stall_cnt <= '0;
    else if (core_run && if_req && !if_gnt && (if_stall_cnt != 16'hFFFF))
      if_stall_cnt <= if_stall_cnt + 16'd1;
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a behavioural memory and read-response scoreboard.
module tb_mips_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, core_halted, core_run;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   if_stall_cnt;

  mips_mem_arbiter #(.AW(AW), .DW(DW), .IF_MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .core_halted(core_halted), .core_run(core_run),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .if_stall_cnt(if_stall_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data one cycle after the strobe.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         if_q[$], dm_q[$], dbg_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic rv, input logic [DW-1:0] rd,
                          inout resp_t q[$]);
    logic ev;
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk({tag, "_rvalid"}, 32'(rv), 32'(ev));
    if (ev) begin
      chk({tag, "_rdata"}, rd, q[0].data);
      void'(q.pop_front());
    end
  endtask

  task automatic idle_inputs();
    start = 0; core_halted = 0;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  // One clock: check grants/run/responses at negedge, update scoreboard, advance.
  task automatic step(input bit e_if, input bit e_dm, input bit e_dbg, input bit e_run,
                      input string tag);
    resp_t r;
    @(negedge clk);
    chk_port({tag, ":if"}, if_rvalid, if_rdata, if_q);
    chk_port({tag, ":dm"}, dm_rvalid, dm_rdata, dm_q);
    chk_port({tag, ":dbg"}, dbg_rvalid, dbg_rdata, dbg_q);
    chk({tag, ":if_gnt"},   32'(if_gnt),   32'(e_if));
    chk({tag, ":dm_gnt"},   32'(dm_gnt),   32'(e_dm));
    chk({tag, ":dbg_gnt"},  32'(dbg_gnt),  32'(e_dbg));
    chk({tag, ":core_run"}, 32'(core_run), 32'(e_run));
    chk({tag, ":mem_en"},   32'(mem_en),   32'(e_if | e_dm | e_dbg));
    if (!(e_if | e_dm | e_dbg)) begin
      chk({tag, ":mem_we_idle"},   32'(mem_we),   32'd0);
      chk({tag, ":mem_addr_idle"}, 32'(mem_addr), 32'd0);
    end
    r.due = cyc + 1;
    if (e_dbg) begin
      if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
      else begin r.data = ref_mem[dbg_addr]; dbg_q.push_back(r); end
    end else if (e_dm) begin
      if (dm_we) ref_mem[dm_addr] = dm_wdata;
      else begin r.data = ref_mem[dm_addr]; dm_q.push_back(r); end
    end else if (e_if) begin
      r.data = ref_mem[if_addr]; if_q.push_back(r);
    end
    @(posedge clk); cyc++; #1;
  endtask

  logic [DW-1:0] prog [0:8];

  initial begin
    prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
    prog[3] = 32'h00432020; prog[4] = 32'h00642822; prog[5] = 32'h00222000;
    prog[6] = 32'hac050001; prog[7] = 32'h8c060001; prog[8] = 32'hfc000000;
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:core_run", 32'(core_run), 32'd0);
    chk("rst:rvalids",  32'({if_rvalid, dm_rvalid, dbg_rvalid}), 32'd0);
    chk("rst:if_rdata", if_rdata, 32'd0);
    chk("rst:dm_rdata", dm_rdata, 32'd0);
    chk("rst:dbg_rdata", dbg_rdata, 32'd0);
    chk("rst:stall",    32'(if_stall_cnt), 32'd0);
    rst_n = 1;
    @(posedge clk); cyc++; #1;

    // 1: boot load through debug port; fetch must stay blocked.
    for (int i = 0; i < 9; i++) begin
      dbg_req = 1; dbg_we = 1; dbg_addr = AW'(i); dbg_wdata = prog[i];
      if_req = 1; if_addr = AW'(i);
      step(0, 0, 1, 0, "boot_wr");
    end
    idle_inputs();
    dbg_req = 1; dbg_addr = 10'd5;
    step(0, 0, 1, 0, "boot_rd");
    idle_inputs();
    step(0, 0, 0, 0, "boot_rd_resp");

    // 2: start, then back-to-back fetches.
    start = 1;
    step(0, 0, 0, 0, "start");
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      if_req = 1; if_addr = AW'(i);
      step(1, 0, 0, 1, "fetch");
    end
    idle_inputs();
    step(0, 0, 0, 1, "fetch_tail");

    // 3: DM and IF contend; IF forced every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      if_req = 1; if_addr = AW'(i % 3);
      dm_req = 1; dm_addr = 10'd8;
      step((i % 5) == 4, (i % 5) != 4, 0, 1, "contend");
    end
    idle_inputs();
    step(0, 0, 0, 1, "contend_tail");
    chk("contend:stall_cnt", 32'(if_stall_cnt), 32'd8);

    // 4: halt with a load in flight; start in the same cycle is ignored.
    dm_req = 1; dm_we = 1; dm_addr = 10'd9; dm_wdata = 32'hdeadbeef;
    step(0, 1, 0, 1, "dm_store");
    idle_inputs();
    dm_req = 1; dm_addr = 10'd5; core_halted = 1; start = 1;
    step(0, 1, 0, 1, "halt_load");
    idle_inputs();
    dbg_req = 1; dbg_addr = 10'd9; if_req = 1;
    step(0, 0, 0, 0, "drain");
    step(0, 0, 1, 0, "halted_dbg");
    idle_inputs();
    step(0, 0, 0, 0, "halted_resp");

    // 5: reset while a fetch read is in flight.
    start = 1;
    step(0, 0, 0, 0, "restart");
    idle_inputs();
    if_req = 1; if_addr = 10'd1;
    @(negedge clk);
    chk("rst5:if_gnt", 32'(if_gnt), 32'd1);
    @(posedge clk); cyc++; #1;
    rst_n = 0;
    #1;
    chk("rst5:if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst5:core_run",  32'(core_run), 32'd0);
    chk("rst5:stall",     32'(if_stall_cnt), 32'd0);
    @(posedge clk); cyc++; #1;
    rst_n = 1;
    step(0, 0, 0, 0, "rst5_boot");

    // 6: debug locked out in RUN; resume from HALTED.
    idle_inputs();
    start = 1;
    step(0, 0, 0, 0, "start6");
    idle_inputs();
    dbg_req = 1; dbg_addr = 10'd3;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, "dbg_in_run");
    idle_inputs();
    core_halted = 1;
    step(0, 0, 0, 1, "halt6");
    idle_inputs();
    step(0, 0, 0, 0, "drain6");
    start = 1;
    step(0, 0, 0, 0, "resume");
    idle_inputs();
    if_req = 1; if_addr = 10'd2;
    step(1, 0, 0, 1, "resume_fetch");
    idle_inputs();
    step(0, 0, 0, 1, "resume_tail");

    chk("sb:pending", 32'(if_q.size() + dm_q.size() + dbg_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
